// File: rtl/ov7670_capture_if.sv
// Camera-side and frame-buffer-side signals of the OV7670 capture block.
// slave: the capture block; master: whoever drives the camera lines.
interface ov7670_capture_if;
  logic        ENABLE_I;
  logic        CAM_VSYNC_I;
  logic        CAM_HREF_I;
  logic [7:0]  CAM_DATA_I;
  logic [11:0] PXL_O;
  logic        WR_EN_O;
  logic [14:0] ADDRESS_O;
  logic        FRAME_DONE_O;

  modport master (
    output ENABLE_I,
    output CAM_VSYNC_I,
    output CAM_HREF_I,
    output CAM_DATA_I,
    input  PXL_O,
    input  WR_EN_O,
    input  ADDRESS_O,
    input  FRAME_DONE_O
  );

  modport slave (
    input  ENABLE_I,
    input  CAM_VSYNC_I,
    input  CAM_HREF_I,
    input  CAM_DATA_I,
    output PXL_O,
    output WR_EN_O,
    output ADDRESS_O,
    output FRAME_DONE_O
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels and writes them to a frame buffer.
// Define CAP_SKIP_FRAMES_EN to discard the first SKIP_FRAMES_C frames after each enable.
module ov7670_capture #(
  parameter int unsigned MAX_ADDRESS_C = 30720,
  parameter int unsigned SKIP_FRAMES_C = 2
) (
  input logic             CLK_PCLK_I,
  input logic             RST_I,
  ov7670_capture_if.slave bus
);

  localparam logic [14:0] AddrLast = 15'(MAX_ADDRESS_C - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitFrame,
    StCapture
  } state_e;

  state_e      state_q, state_d;
  logic        vs_cur_q, vs_prev_q;
  logic        phase_q, phase_d;
  logic [3:0]  red_q, red_d;
  logic [11:0] pxl_q, pxl_d;
  logic        wr_en_q, wr_en_d;
  logic [14:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        vs_fall, vs_rise;
  logic        wr_allow;

  assign vs_fall = vs_prev_q & ~vs_cur_q;
  assign vs_rise = vs_cur_q & ~vs_prev_q;

`ifdef CAP_SKIP_FRAMES_EN
  localparam int unsigned SkipW = (SKIP_FRAMES_C < 1) ? 1 : $clog2(SKIP_FRAMES_C + 1);
  localparam logic [SkipW-1:0] SkipMax = SkipW'(SKIP_FRAMES_C);

  logic [SkipW-1:0] skip_q, skip_d;

  // Counts completed frames since enable and saturates once writing may begin.
  always_comb begin
    skip_d = skip_q;
    if (bus.ENABLE_I && state_q == StIdle) begin
      skip_d = '0;
    end else if (bus.ENABLE_I && state_q == StCapture && vs_rise && skip_q != SkipMax) begin
      skip_d = skip_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_PCLK_I or posedge RST_I) begin
    if (RST_I) begin
      skip_q <= '0;
    end else begin
      skip_q <= skip_d;
    end
  end

  assign wr_allow = (skip_q == SkipMax);
`else
  assign wr_allow = 1'b1;

  // Frame skipping is compiled out; SKIP_FRAMES_C has no effect in this build.
  if (SKIP_FRAMES_C > 0) begin : g_no_skip
  end
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    red_d   = red_q;
    pxl_d   = pxl_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;

    // Address advances in the cycle after each strobe; frame start/end override it below.
    if (wr_en_q) begin
      addr_d = (addr_q == AddrLast) ? 15'd0 : addr_q + 15'd1;
    end

    if (!bus.ENABLE_I) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWaitFrame;
        end
        StWaitFrame: begin
          if (vs_fall) begin
            state_d = StCapture;
            phase_d = 1'b0;
            addr_d  = 15'd0;
          end
        end
        StCapture: begin
          if (vs_rise) begin
            state_d = StWaitFrame;
            phase_d = 1'b0;
            addr_d  = 15'd0;
            done_d  = wr_allow;
          end else if (bus.CAM_HREF_I) begin
            if (!phase_q) begin
              red_d   = bus.CAM_DATA_I[3:0];
              phase_d = 1'b1;
            end else begin
              pxl_d   = {red_q, bus.CAM_DATA_I};
              wr_en_d = wr_allow;
              phase_d = 1'b0;
            end
          end else begin
            phase_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_PCLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= StIdle;
      vs_cur_q  <= 1'b0;
      vs_prev_q <= 1'b0;
      phase_q   <= 1'b0;
      red_q     <= 4'd0;
      pxl_q     <= 12'd0;
      wr_en_q   <= 1'b0;
      addr_q    <= 15'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_cur_q  <= bus.CAM_VSYNC_I;
      vs_prev_q <= vs_cur_q;
      phase_q   <= phase_d;
      red_q     <= red_d;
      pxl_q     <= pxl_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  assign bus.PXL_O        = pxl_q;
  assign bus.WR_EN_O      = wr_en_q;
  assign bus.ADDRESS_O    = addr_q;
  assign bus.FRAME_DONE_O = done_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: drives camera timing, logs every write and frame-done pulse.
module tb_ov7670_capture;

  logic clk = 1'b0;
  logic rst;

  ov7670_capture_if cam_if ();

  ov7670_capture #(
    .MAX_ADDRESS_C(30720),
    .SKIP_FRAMES_C(2)
  ) dut (
    .CLK_PCLK_I(clk),
    .RST_I     (rst),
    .bus       (cam_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned fd_cycles = 0;
  int unsigned fd_pulses = 0;
  int unsigned bad;
  logic        fd_prev = 1'b0;
  logic [14:0] wr_addr_q[$];
  logic [11:0] wr_pxl_q[$];

  // Write/frame-done log, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (cam_if.WR_EN_O) begin
        wr_addr_q.push_back(cam_if.ADDRESS_O);
        wr_pxl_q.push_back(cam_if.PXL_O);
      end
      if (cam_if.FRAME_DONE_O) begin
        fd_cycles++;
        if (!fd_prev) fd_pulses++;
      end
    end
    fd_prev = cam_if.FRAME_DONE_O;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cam_if.CAM_HREF_I = 1'b1;
    cam_if.CAM_DATA_I = b;
  endtask

  task automatic line_end();
    @(negedge clk);
    cam_if.CAM_HREF_I = 1'b0;
    cam_if.CAM_DATA_I = 8'h00;
  endtask

  task automatic start_frame();
    @(negedge clk);
    cam_if.CAM_HREF_I  = 1'b0;
    cam_if.CAM_VSYNC_I = 1'b1;
    tick(3);
    cam_if.CAM_VSYNC_I = 1'b0;
    tick(3);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cam_if.CAM_HREF_I  = 1'b0;
    cam_if.CAM_VSYNC_I = 1'b1;
    tick(4);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_pxl_q.delete();
    fd_cycles = 0;
    fd_pulses = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    cam_if.ENABLE_I    = 1'b0;
    cam_if.CAM_VSYNC_I = 1'b0;
    cam_if.CAM_HREF_I  = 1'b0;
    cam_if.CAM_DATA_I  = 8'h00;
    tick(2);
    check("rst_pxl", 32'(cam_if.PXL_O), 32'h0);
    check("rst_wr_en", 32'(cam_if.WR_EN_O), 32'h0);
    check("rst_addr", 32'(cam_if.ADDRESS_O), 32'h0);
    check("rst_done", 32'(cam_if.FRAME_DONE_O), 32'h0);
    rst             = 1'b0;
    cam_if.ENABLE_I = 1'b1;
    tick(2);

`ifdef CAP_SKIP_FRAMES_EN
    clear_log();
    for (int f = 1; f <= 3; f++) begin
      start_frame();
      send_byte(8'(f));
      send_byte(8'(8'h40 + f));
      send_byte(8'(f));
      send_byte(8'(8'h50 + f));
      line_end();
      tick(2);
      end_frame();
      if (f == 2) begin
        check("skip_no_writes_f1_f2", wr_addr_q.size(), 0);
        check("skip_no_done_f1_f2", fd_pulses, 0);
      end
    end
    check("skip_writes_f3", wr_addr_q.size(), 2);
    check("skip_pxl0_f3", 32'(wr_pxl_q[0]), 32'h343);
    check("skip_addr1_f3", 32'(wr_addr_q[1]), 32'h1);
    check("skip_done_f3", fd_pulses, 1);
`else
    // First pixel of first frame.
    clear_log();
    start_frame();
    send_byte(8'h0A);
    send_byte(8'h5C);
    line_end();
    tick(3);
    check("first_count", wr_addr_q.size(), 1);
    check("first_pxl", 32'(wr_pxl_q[0]), 32'hA5C);
    check("first_addr", 32'(wr_addr_q[0]), 32'h0);
    check("first_addr_after", 32'(cam_if.ADDRESS_O), 32'h1);

    // Odd-length line drops its last byte; next line restarts at phase 0.
    clear_log();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    line_end();
    tick(2);
    send_byte(8'h08);
    send_byte(8'h9A);
    line_end();
    tick(3);
    check("odd_count", wr_addr_q.size(), 4);
    check("odd_pxl0", 32'(wr_pxl_q[0]), 32'h122);
    check("odd_pxl1", 32'(wr_pxl_q[1]), 32'h344);
    check("odd_pxl2", 32'(wr_pxl_q[2]), 32'h566);
    check("odd_addr2", 32'(wr_addr_q[2]), 32'h3);
    check("next_line_pxl", 32'(wr_pxl_q[3]), 32'h89A);
    check("next_line_addr", 32'(wr_addr_q[3]), 32'h4);

    // Enable low: no writes, pixel and address kept.
    clear_log();
    cam_if.ENABLE_I = 1'b0;
    tick(2);
    send_byte(8'h01);
    send_byte(8'h23);
    line_end();
    tick(2);
    check("dis_count", wr_addr_q.size(), 0);
    check("dis_pxl_kept", 32'(cam_if.PXL_O), 32'h89A);
    check("dis_addr_kept", 32'(cam_if.ADDRESS_O), 32'h5);
    cam_if.ENABLE_I = 1'b1;
    tick(2);

    // Ten pixels, VSYNC rises right after the tenth.
    clear_log();
    start_frame();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'(i));
      send_byte(8'(8'h10 + i));
    end
    end_frame();
    check("ten_count", wr_addr_q.size(), 10);
    check("ten_last_addr", 32'(wr_addr_q[9]), 32'h9);
    check("ten_last_pxl", 32'(wr_pxl_q[9]), 32'h919);
    check("ten_done_pulses", fd_pulses, 1);
    check("ten_done_width", fd_cycles, 1);
    check("ten_addr_reset", 32'(cam_if.ADDRESS_O), 32'h0);

    // HREF while waiting for frame start is ignored.
    clear_log();
    send_byte(8'h0F);
    send_byte(8'hFF);
    line_end();
    tick(2);
    check("wait_href_ignored", wr_addr_q.size(), 0);

    // VSYNC rise together with the second byte: write completes, then address resets.
    clear_log();
    start_frame();
    send_byte(8'h01); send_byte(8'h23);
    send_byte(8'h04); send_byte(8'h56);
    send_byte(8'h0C);
    @(negedge clk);
    cam_if.CAM_DATA_I  = 8'hDE;
    cam_if.CAM_VSYNC_I = 1'b1;
    line_end();
    tick(4);
    check("coll_count", wr_addr_q.size(), 3);
    check("next_frame_first_addr", 32'(wr_addr_q[0]), 32'h0);
    check("coll_addr", 32'(wr_addr_q[2]), 32'h2);
    check("coll_pxl", 32'(wr_pxl_q[2]), 32'hCDE);
    check("coll_done", fd_pulses, 1);
    check("coll_addr_reset", 32'(cam_if.ADDRESS_O), 32'h0);

    // 30721 pixels: address wraps from 30719 to 0 without a lost strobe.
    clear_log();
    start_frame();
    for (int i = 0; i < 30721; i++) begin
      send_byte(8'(i & 15));
      send_byte(8'(i >> 4));
    end
    line_end();
    tick(3);
    check("wrap_count", wr_addr_q.size(), 30721);
    check("wrap_addr_top", 32'(wr_addr_q[30719]), 32'd30719);
    check("wrap_addr_zero", 32'(wr_addr_q[30720]), 32'h0);
    check("wrap_pxl_last", 32'(wr_pxl_q[30720]), 32'h080);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != 15'(i % 30720)) bad++;
    end
    check("wrap_addr_seq_errors", bad, 0);
    end_frame();

    // Asynchronous reset mid-line.
    clear_log();
    start_frame();
    send_byte(8'h0F);
    send_byte(8'hED);
    send_byte(8'h03);
    #1;
    check("pre_rst_pxl", 32'(cam_if.PXL_O), 32'hFED);
    #1;
    rst = 1'b1;
    #1;
    check("arst_pxl", 32'(cam_if.PXL_O), 32'h0);
    check("arst_wr_en", 32'(cam_if.WR_EN_O), 32'h0);
    check("arst_addr", 32'(cam_if.ADDRESS_O), 32'h0);
    check("arst_done", 32'(cam_if.FRAME_DONE_O), 32'h0);
    tick(2);
    rst = 1'b0;
    clear_log();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    line_end();
    tick(3);
    check("post_rst_no_write", wr_addr_q.size(), 0);
    start_frame();
    send_byte(8'h12);
    send_byte(8'h34);
    line_end();
    tick(3);
    check("post_rst_count", wr_addr_q.size(), 1);
    check("post_rst_addr", 32'(wr_addr_q[0]), 32'h0);
    check("post_rst_pxl", 32'(wr_pxl_q[0]), 32'h234);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
